// File: rtl/id_stage_hz.sv
// rtl/id_stage_hz.sv - MIPS decode stage: regfile, forwarding, load-use stall, flush, ID/EX register
// Optional debug ports and stall counter are built when ID_DEBUG_PORTS_EN is defined.
module id_stage_hz #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int REG_AW = 5,
  parameter int IMM_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_valid,
  input  logic [31:0]       if_inst,
  input  logic [ADDR_W-1:0] if_pc4,
  input  logic              cu_sext,
  input  logic              cu_rs_used,
  input  logic              cu_rt_used,
  input  logic              flush,
  input  logic              ex_wreg,
  input  logic              ex_m2reg,
  input  logic [REG_AW-1:0] ex_destR,
  input  logic [DATA_W-1:0] ex_result,
  input  logic              mem_wreg,
  input  logic [REG_AW-1:0] mem_destR,
  input  logic [DATA_W-1:0] mem_result,
  input  logic              wb_wreg,
  input  logic [REG_AW-1:0] wb_destR,
  input  logic [DATA_W-1:0] wb_dest,
  output logic              id_stall,
  output logic              id_valid,
  output logic [ADDR_W-1:0] id_pc4,
  output logic [DATA_W-1:0] id_inA,
  output logic [DATA_W-1:0] id_inB,
  output logic [DATA_W-1:0] id_imm,
  output logic [REG_AW-1:0] rs,
  output logic [REG_AW-1:0] rt,
  output logic [REG_AW-1:0] rd
`ifdef ID_DEBUG_PORTS_EN
  ,
  input  logic [REG_AW-1:0] which_reg,
  output logic [DATA_W-1:0] reg_content,
  input  logic [3:0]        IF_ins_type,
  input  logic [3:0]        IF_ins_number,
  output logic [3:0]        ID_ins_type,
  output logic [3:0]        ID_ins_number,
  output logic [15:0]       stall_cnt
`endif
);

  localparam int NREG = 1 << REG_AW;

  logic [DATA_W-1:0] regs [NREG];
  logic [REG_AW-1:0] rs_f, rt_f, rd_f;
  logic [IMM_W-1:0]  imm_f;
  logic [DATA_W-1:0] imm_ext;
  logic [DATA_W-1:0] op_a, op_b;
  logic              hz;

  assign rs_f  = if_inst[21 +: REG_AW];
  assign rt_f  = if_inst[16 +: REG_AW];
  assign rd_f  = if_inst[11 +: REG_AW];
  assign imm_f = if_inst[IMM_W-1:0];

  // Extend the immediate; the fill bit is the sign bit only when sign extension is requested
  assign imm_ext = {{(DATA_W-IMM_W){imm_f[IMM_W-1] & cu_sext}}, imm_f};

  // A load still in EX cannot supply its data yet; a killed instruction never needs to wait
  assign hz = if_valid && !flush && ex_wreg && ex_m2reg && (ex_destR != '0) &&
              ((cu_rs_used && (rs_f == ex_destR)) || (cu_rt_used && (rt_f == ex_destR)));

  assign id_stall = hz;

  // Register file; entry 0 is never written so it always reads zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (wb_wreg && (wb_destR != '0)) begin
      regs[wb_destR] <= wb_dest;
    end
  end

  // rs operand: youngest producer wins, WB gives same-cycle write-through
  always_comb begin
    op_a = regs[rs_f];
    if (rs_f == '0)                                        op_a = '0;
    else if (ex_wreg && (ex_destR == rs_f) && !ex_m2reg)   op_a = ex_result;
    else if (mem_wreg && (mem_destR == rs_f))              op_a = mem_result;
    else if (wb_wreg && (wb_destR == rs_f))                op_a = wb_dest;
  end

  // rt operand: same priority as rs
  always_comb begin
    op_b = regs[rt_f];
    if (rt_f == '0)                                        op_b = '0;
    else if (ex_wreg && (ex_destR == rt_f) && !ex_m2reg)   op_b = ex_result;
    else if (mem_wreg && (mem_destR == rt_f))              op_b = mem_result;
    else if (wb_wreg && (wb_destR == rt_f))                op_b = wb_dest;
  end

  // ID/EX register: flush, hazard or empty slot all produce an all-zero bubble
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_valid <= 1'b0;
      id_pc4   <= '0;
      id_inA   <= '0;
      id_inB   <= '0;
      id_imm   <= '0;
      rs       <= '0;
      rt       <= '0;
      rd       <= '0;
    end else if (flush || hz || !if_valid) begin
      id_valid <= 1'b0;
      id_pc4   <= '0;
      id_inA   <= '0;
      id_inB   <= '0;
      id_imm   <= '0;
      rs       <= '0;
      rt       <= '0;
      rd       <= '0;
    end else begin
      id_valid <= 1'b1;
      id_pc4   <= if_pc4;
      id_inA   <= op_a;
      id_inB   <= op_b;
      id_imm   <= imm_ext;
      rs       <= rs_f;
      rt       <= rt_f;
      rd       <= rd_f;
    end
  end

`ifdef ID_DEBUG_PORTS_EN
  assign reg_content = regs[which_reg];

  // Instruction tags travel with the payload and are cleared on bubbles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ID_ins_type   <= '0;
      ID_ins_number <= '0;
    end else if (flush || hz || !if_valid) begin
      ID_ins_type   <= '0;
      ID_ins_number <= '0;
    end else begin
      ID_ins_type   <= IF_ins_type;
      ID_ins_number <= IF_ins_number;
    end
  end

  // Saturating count of stalled cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (hz && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_id_stage_hz.sv
// tb/tb_id_stage_hz.sv - scoreboard bench for id_stage_hz
module tb_id_stage_hz;

  typedef struct {
    logic        valid;
    logic [31:0] pc4;
    logic [31:0] ina;
    logic [31:0] inb;
    logic [31:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_valid;
  logic [31:0] if_inst;
  logic [31:0] if_pc4;
  logic        cu_sext, cu_rs_used, cu_rt_used, flush;
  logic        ex_wreg, ex_m2reg;
  logic [4:0]  ex_destR;
  logic [31:0] ex_result;
  logic        mem_wreg;
  logic [4:0]  mem_destR;
  logic [31:0] mem_result;
  logic        wb_wreg;
  logic [4:0]  wb_destR;
  logic [31:0] wb_dest;
  logic        id_stall, id_valid;
  logic [31:0] id_pc4, id_inA, id_inB, id_imm;
  logic [4:0]  rs, rt, rd;
`ifdef ID_DEBUG_PORTS_EN
  logic [4:0]  which_reg = '0;
  logic [31:0] reg_content;
  logic [3:0]  IF_ins_type = '0, IF_ins_number = '0, ID_ins_type, ID_ins_number;
  logic [15:0] stall_cnt;
`endif

  int checks = 0;
  int errors = 0;
  exp_t sb[$];

  id_stage_hz dut (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_inst(if_inst), .if_pc4(if_pc4),
    .cu_sext(cu_sext), .cu_rs_used(cu_rs_used), .cu_rt_used(cu_rt_used), .flush(flush),
    .ex_wreg(ex_wreg), .ex_m2reg(ex_m2reg), .ex_destR(ex_destR), .ex_result(ex_result),
    .mem_wreg(mem_wreg), .mem_destR(mem_destR), .mem_result(mem_result),
    .wb_wreg(wb_wreg), .wb_destR(wb_destR), .wb_dest(wb_dest),
    .id_stall(id_stall), .id_valid(id_valid), .id_pc4(id_pc4),
    .id_inA(id_inA), .id_inB(id_inB), .id_imm(id_imm), .rs(rs), .rt(rt), .rd(rd)
`ifdef ID_DEBUG_PORTS_EN
    , .which_reg(which_reg), .reg_content(reg_content),
    .IF_ins_type(IF_ins_type), .IF_ins_number(IF_ins_number),
    .ID_ins_type(ID_ins_type), .ID_ins_number(ID_ins_number), .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [4:0] s, input logic [4:0] t, input logic [15:0] imm);
    return {6'd0, s, t, imm};
  endfunction

  function automatic exp_t ev(input logic v, input logic [31:0] p, input logic [31:0] a,
                              input logic [31:0] b, input logic [31:0] im,
                              input logic [4:0] s, input logic [4:0] t, input logic [4:0] d);
    exp_t e;
    e.valid = v; e.pc4 = p; e.ina = a; e.inb = b; e.imm = im; e.rs = s; e.rt = t; e.rd = d;
    return e;
  endfunction

  function automatic exp_t bubble();
    return ev(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);
  endfunction

  task automatic idle();
    if_valid = 0; if_inst = 0; if_pc4 = 0; cu_sext = 0; cu_rs_used = 0; cu_rt_used = 0;
    flush = 0; ex_wreg = 0; ex_m2reg = 0; ex_destR = 0; ex_result = 0;
    mem_wreg = 0; mem_destR = 0; mem_result = 0; wb_wreg = 0; wb_destR = 0; wb_dest = 0;
  endtask

  task automatic inst(input logic [4:0] s, input logic [4:0] t, input logic [15:0] imm,
                      input logic [31:0] p);
    if_valid = 1; if_inst = mk(s, t, imm); if_pc4 = p;
  endtask

  // Stimulus is already driven: check the stall, push the expectation, clock, pop and compare
  task automatic step(input string tag, input logic exp_stall, input exp_t e);
    exp_t x;
    #1;
    check({tag, ".stall"}, {31'd0, id_stall}, {31'd0, exp_stall});
    sb.push_back(e);
    @(posedge clk);
    #1;
    x = sb.pop_front();
    check({tag, ".valid"}, {31'd0, id_valid}, {31'd0, x.valid});
    check({tag, ".pc4"}, id_pc4, x.pc4);
    check({tag, ".inA"}, id_inA, x.ina);
    check({tag, ".inB"}, id_inB, x.inb);
    check({tag, ".imm"}, id_imm, x.imm);
    check({tag, ".rs"}, {27'd0, rs}, {27'd0, x.rs});
    check({tag, ".rt"}, {27'd0, rt}, {27'd0, x.rt});
    check({tag, ".rd"}, {27'd0, rd}, {27'd0, x.rd});
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".valid"}, {31'd0, id_valid}, 32'd0);
    check({tag, ".pc4"}, id_pc4, 32'd0);
    check({tag, ".inA"}, id_inA, 32'd0);
    check({tag, ".inB"}, id_inB, 32'd0);
    check({tag, ".imm"}, id_imm, 32'd0);
    check({tag, ".regs"}, {17'd0, rs, rt, rd}, 32'd0);
  endtask

  initial begin
    idle();
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    check("reset.stall", {31'd0, id_stall}, 32'd0);
    rst = 0;

    // WB writes reg 7 with no instruction in ID
    idle(); wb_wreg = 1; wb_destR = 7; wb_dest = 32'h77;
    step("wb7", 0, bubble());

    // Same-cycle write-through of reg 3
    idle(); inst(3, 0, 16'h0000, 32'h4); cu_rs_used = 1;
    wb_wreg = 1; wb_destR = 3; wb_dest = 32'h1234;
    step("wt3", 0, ev(1, 32'h4, 32'h1234, 0, 0, 3, 0, 0));

    // Regfile holds both written values
    idle(); inst(3, 7, 16'h0800, 32'h8);
    step("rf37", 0, ev(1, 32'h8, 32'h1234, 32'h77, 32'h800, 3, 7, 1));

    // Writes to reg 0 are ignored, both same cycle and afterwards
    idle(); inst(0, 0, 16'h0000, 32'hC);
    wb_wreg = 1; wb_destR = 0; wb_dest = 32'hFFFF;
    step("r0wt", 0, ev(1, 32'hC, 0, 0, 0, 0, 0, 0));
    idle(); inst(0, 0, 16'h0000, 32'h10);
    step("r0rd", 0, ev(1, 32'h10, 0, 0, 0, 0, 0, 0));

    // EX beats MEM
    idle(); inst(5, 0, 16'h0000, 32'h14);
    ex_wreg = 1; ex_destR = 5; ex_result = 32'hA;
    mem_wreg = 1; mem_destR = 5; mem_result = 32'hB;
    step("exmem", 0, ev(1, 32'h14, 32'hA, 0, 0, 5, 0, 0));

    // EX not writing: MEM supplies
    ex_wreg = 0; if_pc4 = 32'h18;
    step("mem", 0, ev(1, 32'h18, 32'hB, 0, 0, 5, 0, 0));

    // Load in EX is never forwarded; operand not used so no stall
    ex_wreg = 1; ex_m2reg = 1; if_pc4 = 32'h1C;
    step("ldnofwd", 0, ev(1, 32'h1C, 32'hB, 0, 0, 5, 0, 0));

    // Load-use on rt: one stall cycle and a bubble
    idle(); inst(0, 8, 16'h0000, 32'h20); cu_rt_used = 1;
    ex_wreg = 1; ex_m2reg = 1; ex_destR = 8;
    step("lu.stall", 1, bubble());

    // Load now in MEM
    idle(); inst(0, 8, 16'h0000, 32'h20); cu_rt_used = 1;
    mem_wreg = 1; mem_destR = 8; mem_result = 32'hCAFE;
    step("lu.mem", 0, ev(1, 32'h20, 0, 32'hCAFE, 0, 0, 8, 0));

    // Same load, rt not used: no stall
    idle(); inst(0, 8, 16'h0000, 32'h24);
    ex_wreg = 1; ex_m2reg = 1; ex_destR = 8;
    step("lu.unused", 0, ev(1, 32'h24, 0, 0, 0, 0, 8, 0));

    // Flush overrides the hazard
    idle(); inst(0, 8, 16'h0000, 32'h28); cu_rt_used = 1;
    ex_wreg = 1; ex_m2reg = 1; ex_destR = 8; flush = 1;
    step("flush", 0, bubble());
    idle();
    step("flush.after", 0, bubble());

    // Immediate extension
    idle(); inst(0, 0, 16'h8001, 32'h2C); cu_sext = 1;
    step("sext", 0, ev(1, 32'h2C, 0, 0, 32'hFFFF8001, 0, 0, 16));
    cu_sext = 0; if_pc4 = 32'h30;
    step("zext", 0, ev(1, 32'h30, 0, 0, 32'h00008001, 0, 0, 16));

    // Load to reg 0 never stalls
    idle(); inst(0, 0, 16'h0000, 32'h34); cu_rt_used = 1; cu_rs_used = 1;
    ex_wreg = 1; ex_m2reg = 1; ex_destR = 0;
    step("lu.r0", 0, ev(1, 32'h34, 0, 0, 0, 0, 0, 0));

    // Load a real payload, then reset asynchronously in mid-stall
    idle(); inst(3, 7, 16'h0001, 32'h38);
    step("pre", 0, ev(1, 32'h38, 32'h1234, 32'h77, 32'h1, 3, 7, 0));
    idle(); inst(0, 8, 16'h0000, 32'h3C); cu_rt_used = 1;
    ex_wreg = 1; ex_m2reg = 1; ex_destR = 8;
    #2;
    rst = 1;
    #1;
    check_zero("arst");
    check("arst.stall", {31'd0, id_stall}, 32'd1);
    @(posedge clk);
    #1;
    rst = 0;

    // Regfile cleared by reset
    idle(); inst(7, 3, 16'h0000, 32'h40);
    step("postrst", 0, ev(1, 32'h40, 0, 0, 0, 7, 3, 0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_stage_hz.md
Name: id_stage_hz

Overview:
Parametrised decode stage for the 5-stage MIPS pipeline. It contains:
- the register file, with write-through from WB;
- operand forwarding from EX, MEM and WB;
- load-use hazard detection, with IF stall and bubble insertion;
- branch flush;
- a registered ID/EX payload with a valid bit.

It sits between the IF/ID latch and the EX stage. It consumes control bits from the external control unit decoding the same instruction.

Parameters:
DATA_W, 32, register/operand width
ADDR_W, 32, PC width
REG_AW, 5, register address width; file holds 2**REG_AW entries, entry 0 hardwired to zero
IMM_W, 16, immediate field width (if_inst[IMM_W-1:0]); must be < DATA_W

Ports:
clk  in  1  pipeline clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
if_valid  in  1  IF/ID holds a real instruction
if_inst  in  32  instruction; rs=[25:21], rt=[20:16], rd=[15:11]
if_pc4  in  ADDR_W  PC+4 of if_inst
cu_sext  in  1  sign-extend immediate (else zero-extend)
cu_rs_used  in  1  instruction reads rs
cu_rt_used  in  1  instruction reads rt
flush  in  1  taken branch resolved in EX; kill instruction in ID
ex_wreg, ex_m2reg  in  1,1  instruction now in EX writes reg / is a load
ex_destR  in  REG_AW  its destination
ex_result  in  DATA_W  its ALU result (combinational)
mem_wreg  in  1  instruction in MEM writes reg
mem_destR  in  REG_AW  its destination
mem_result  in  DATA_W  its final value (load data or ALU result)
wb_wreg  in  1  regfile write enable
wb_destR  in  REG_AW  regfile write address
wb_dest  in  DATA_W  regfile write data
id_stall  out  1  hold PC and IF/ID this cycle (combinational)
id_valid  out  1  ID/EX holds a real instruction
id_pc4  out  ADDR_W  registered PC+4
id_inA, id_inB  out  DATA_W  registered forwarded rs/rt operands
id_imm  out  DATA_W  registered extended immediate
rs, rt, rd  out  REG_AW  registered register addresses

Behaviour:
- Reset (asynchronous, any time including mid-stall): all registered outputs 0, including id_valid.
  - Register file cleared to 0.
  - id_stall is combinational and reflects inputs.
- Regfile: write at posedge when wb_wreg && wb_destR!=0; writes to reg 0 ignored.
- Operand select (per operand, address a = rs or rt), priority high to low:
  1. a==0 -> 0
  2. ex_wreg && ex_destR==a && !ex_m2reg -> ex_result
  3. mem_wreg && mem_destR==a -> mem_result
  4. wb_wreg && wb_destR==a -> wb_dest (same-cycle write-through)
  5. otherwise regfile contents
- Load-use hazard: hz = if_valid && !flush && ex_wreg && ex_m2reg && ex_destR!=0 && ((cu_rs_used && rs_f==ex_destR) || (cu_rt_used && rt_f==ex_destR)).
  - rs_f/rt_f are the if_inst fields.
  - id_stall = hz.
- ID/EX update each posedge, first match wins:
  1. flush -> bubble
  2. hz -> bubble
  3. !if_valid -> bubble
  4. otherwise load: id_valid=1, pc4, forwarded operands, id_imm, rs/rt/rd.
- Bubble: id_valid=0 and all payload fields 0.
- Stall lasts exactly one cycle per load. Next cycle the load is in MEM and is forwarded from mem_result.
- Immediate extension: cu_sext ? sign-extend imm to DATA_W : zero-extend.
- Latency: one cycle from if_inst to ID/EX outputs.
- Flush with hz asserted: flush wins, id_stall=0.

Optional Feature:
ID_DEBUG_PORTS_EN.
- Defined: adds these ports.
  - which_reg (in, REG_AW) and reg_content (out, DATA_W): combinational regfile read, no forwarding.
  - IF_ins_type/IF_ins_number (in, 4 each) and ID_ins_type/ID_ins_number (out, 4 each): registered alongside the payload; forced 0 on bubble and on reset.
  - stall_cnt (out, 16): counts cycles with id_stall=1, saturates at 16'hFFFF, reset to 0.
- Undefined: none of these ports or registers exist; all other behaviour is identical.

Test Plan:
- Reset mid-stream -> all outputs 0 asynchronously, before the next edge; id_valid=0. After release, reading reg 7 gives 0.
- WB writes reg 3=32'h1234 while ID decodes an instruction reading rs=3 in the same cycle -> next cycle id_inA=32'h1234. A WB write to reg 0 -> reads of reg 0 return 0.
- EX (ALU, dest 5, result 32'hA) and MEM (dest 5, 32'hB) both target rs=5 -> id_inA=32'hA. With EX not targeting 5, id_inA=32'hB.
- EX load to rt=8, ID instruction reads rt=8 with cu_rt_used=1:
  - Required: id_stall=1 for one cycle, then a bubble (id_valid=0).
  - Next cycle: mem_result=32'hCAFE, so id_inB=32'hCAFE and id_valid=1.
  - Repeat with cu_rt_used=0: no stall.
- Flush and hz asserted together -> id_stall=0 and a bubble. The flushed instruction never appears with id_valid=1.
- imm=16'h8001: cu_sext=1 -> id_imm=32'hFFFF8001; cu_sext=0 -> 32'h00008001.
